// File: rtl/regfile_pkg.sv
// Shared constants and types for the 8 x 32-bit register file and its write-back path.
//   DW       data width
//   AW       register address width
//   NREG     register count (2**AW)
//   wb_req_t one pending write: destination register and data
package regfile_pkg;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 3;
  localparam int unsigned NREG = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/reg_wb_sched_slot.sv
// wb_slot: one-entry holding buffer for a single write-back source.
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   valid_i        source offers a write
//   drain_i        slot contents are taken by the arbiter this cycle
//   req_i          offered write (addr, data)
//   ready_o        slot can take a write this cycle (empty or draining)
//   full_o         slot holds a write
//   req_o          held write
module wb_slot
  import regfile_pkg::*;
(
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    valid_i,
  input  logic    drain_i,
  input  wb_req_t req_i,
  output logic    ready_o,
  output logic    full_o,
  output wb_req_t req_o
);

  logic    full_q, full_d;
  wb_req_t req_q, req_d;

  // Depends only on state and the arbiter's drain, never on valid_i.
  assign ready_o = ~full_q | drain_i;
  assign full_o  = full_q;
  assign req_o   = req_q;

  always_comb begin
    full_d = full_q;
    req_d  = req_q;
    if (valid_i && ready_o) begin
      // A refill on the draining edge keeps the slot full.
      full_d = 1'b1;
      req_d  = req_i;
    end else if (drain_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      req_q  <= '0;
    end else begin
      full_q <= full_d;
      req_q  <= req_d;
    end
  end

endmodule

// File: rtl/reg_wb_sched.sv
// reg_wb_sched: shares the register file's single write port between the ALU (source 0)
// and memory-load (source 1) write-back paths with round-robin arbitration, and keeps a
// per-register busy scoreboard for read-after-write hazard detection.
//   clk, cr                          clock, asynchronous active-low reset
//   s0_*/s1_*                        valid/ready write-back sources with addr and data
//   rf_we, rf_addr_w, rf_di          registered register-file write port
//   claim_valid/claim_addr/ready     issue logic marks a register as pending
//   busy                             scoreboard, bit i = write to Ri outstanding
//   rd_a_addr, rd_b_addr             read port addresses
//   hazard_a, hazard_b               read port targets a busy register
module reg_wb_sched #(
  parameter int unsigned DW   = regfile_pkg::DW,
  parameter int unsigned AW   = regfile_pkg::AW,
  parameter int unsigned NREG = regfile_pkg::NREG
) (
  input  logic            clk,
  input  logic            cr,
  input  logic            s0_valid,
  output logic            s0_ready,
  input  logic [AW-1:0]   s0_addr,
  input  logic [DW-1:0]   s0_data,
  input  logic            s1_valid,
  output logic            s1_ready,
  input  logic [AW-1:0]   s1_addr,
  input  logic [DW-1:0]   s1_data,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr_w,
  output logic [DW-1:0]   rf_di,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_addr,
  output logic            claim_ready,
  output logic [NREG-1:0] busy,
  input  logic [AW-1:0]   rd_a_addr,
  input  logic [AW-1:0]   rd_b_addr,
  output logic            hazard_a,
  output logic            hazard_b
);

  import regfile_pkg::*;

  wb_req_t       slot0_req, slot1_req;
  logic          slot0_full, slot1_full;
  logic          gnt0, gnt1;
  logic          last_grant_q;  // 1: source 1 was granted last
  logic          rf_we_q;
  logic [AW-1:0] rf_addr_q;
  logic [DW-1:0] rf_di_q;
  logic [NREG-1:0] busy_q, busy_d;

  wb_slot u_slot0 (
    .clk_i   (clk),
    .rst_ni  (cr),
    .valid_i (s0_valid),
    .drain_i (gnt0),
    .req_i   ('{addr: s0_addr, data: s0_data}),
    .ready_o (s0_ready),
    .full_o  (slot0_full),
    .req_o   (slot0_req)
  );

  wb_slot u_slot1 (
    .clk_i   (clk),
    .rst_ni  (cr),
    .valid_i (s1_valid),
    .drain_i (gnt1),
    .req_i   ('{addr: s1_addr, data: s1_data}),
    .ready_o (s1_ready),
    .full_o  (slot1_full),
    .req_o   (slot1_req)
  );

  // Round-robin: on contention the source that did not win last time is granted.
  always_comb begin
    gnt0 = slot0_full & (~slot1_full | last_grant_q);
    gnt1 = slot1_full & (~slot0_full | ~last_grant_q);
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      rf_we_q      <= 1'b0;
      rf_addr_q    <= '0;
      rf_di_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      rf_we_q <= gnt0 | gnt1;
      if (gnt0) begin
        rf_addr_q    <= slot0_req.addr;
        rf_di_q      <= slot0_req.data;
        last_grant_q <= 1'b0;
      end else if (gnt1) begin
        rf_addr_q    <= slot1_req.addr;
        rf_di_q      <= slot1_req.data;
        last_grant_q <= 1'b1;
      end
    end
  end

  assign rf_we     = rf_we_q;
  assign rf_addr_w = rf_addr_q;
  assign rf_di     = rf_di_q;

  assign claim_ready = ~busy_q[claim_addr];
  assign hazard_a    = busy_q[rd_a_addr];
  assign hazard_b    = busy_q[rd_b_addr];
  assign busy        = busy_q;

  // Clear first so that a claim on the committing register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_we_q) busy_d[rf_addr_q] = 1'b0;
    if (claim_valid && claim_ready) busy_d[claim_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge cr) begin
    if (!cr) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

endmodule
